// File: rtl/line_refill_engine.sv
// ---------------------------------------------------------------------------
// line_refill_engine
//
// Write-side producer for the instruction-cache data arrays. After a miss it
// issues a single line-read request to memory, accepts 16 response beats,
// packs every four beats into one wide data-array write, and finally pulses
// a fill-done indication so the tag array can validate the refilled way.
//
// Ports:
//   clk, arst_n             clock, asynchronous active-low reset
//   i_halt_all              global stall, freezes all state
//   i_miss_*, o_miss_ready  refill request (tag/set/victim way) handshake
//   o_mem_req_*, i_mem_req_ready   line-read request to memory ({tag, set})
//   i_mem_data*, o_mem_data_ready  response beats from memory
//   o_w_*                   data-array write port (set/way/row/data/strobe)
//   o_stop_write_clk        inverse of the write strobe, gates the array clock
//   o_fill_done, o_fill_*   one-cycle completion pulse and line identity
// ---------------------------------------------------------------------------
module line_refill_engine #(
    parameter int SET_BITS_WIDTH      = 4,
    parameter int TAG_BITS_WIDTH      = 8,
    parameter int NUM_WAYS            = 4,
    parameter int B_OFFSET_BITS_WIDTH = 4,
    parameter int WORD_WIDTH          = 20
) (
    input  logic                                     clk,
    input  logic                                     arst_n,
    input  logic                                     i_halt_all,
    input  logic                                     i_miss_valid,
    input  logic [TAG_BITS_WIDTH-1:0]                i_miss_tag,
    input  logic [SET_BITS_WIDTH-1:0]                i_miss_set,
    input  logic [$clog2(NUM_WAYS)-1:0]              i_miss_way,
    output logic                                     o_miss_ready,
    output logic                                     o_mem_req_valid,
    output logic [TAG_BITS_WIDTH+SET_BITS_WIDTH-1:0] o_mem_req_addr,
    input  logic                                     i_mem_req_ready,
    input  logic [WORD_WIDTH-1:0]                    i_mem_data,
    input  logic                                     i_mem_data_valid,
    output logic                                     o_mem_data_ready,
    output logic [SET_BITS_WIDTH-1:0]                o_w_set_bits,
    output logic [$clog2(NUM_WAYS)-1:0]              o_w_way_index,
    output logic [B_OFFSET_BITS_WIDTH-3:0]           o_w_block_offset_bits,
    output logic [WORD_WIDTH*4-1:0]                  o_w_data,
    output logic                                     o_w_valid,
    output logic                                     o_stop_write_clk,
    output logic                                     o_fill_done,
    output logic [TAG_BITS_WIDTH-1:0]                o_fill_tag,
    output logic [SET_BITS_WIDTH-1:0]                o_fill_set,
    output logic [$clog2(NUM_WAYS)-1:0]              o_fill_way
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        FLUSH,
        DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [TAG_BITS_WIDTH-1:0]        tag_q, tag_d;
    logic [SET_BITS_WIDTH-1:0]        set_q, set_d;
    logic [WAY_W-1:0]                 way_q, way_d;
    logic [B_OFFSET_BITS_WIDTH-1:0]   beat_q, beat_d;
    // Only lanes 0..2 are stored; lane 3 goes straight into the write word.
    logic [WORD_WIDTH*3-1:0]          pack_q, pack_d;
    logic                             w_valid_q, w_valid_d;
    logic [WORD_WIDTH*4-1:0]          w_data_q, w_data_d;
    logic [B_OFFSET_BITS_WIDTH-3:0]   w_off_q, w_off_d;

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            set_q     <= '0;
            way_q     <= '0;
            beat_q    <= '0;
            pack_q    <= '0;
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
            w_off_q   <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            set_q     <= set_d;
            way_q     <= way_d;
            beat_q    <= beat_d;
            pack_q    <= pack_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
            w_off_q   <= w_off_d;
        end
    end

    // Next-state and handshake logic. Halt suppresses every handshake, so all
    // registers naturally hold; a pending write strobe is kept high so the
    // (also halted) data array still sees it on the first unhalted edge.
    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        set_d            = set_q;
        way_d            = way_q;
        beat_d           = beat_q;
        pack_d           = pack_q;
        w_valid_d        = i_halt_all ? w_valid_q : 1'b0;
        w_data_d         = w_data_q;
        w_off_d          = w_off_q;
        o_miss_ready     = 1'b0;
        o_mem_req_valid  = 1'b0;
        o_mem_data_ready = 1'b0;

        case (state_q)
            IDLE: begin
                o_miss_ready = 1'b1;
                if (i_miss_valid && !i_halt_all) begin
                    tag_d   = i_miss_tag;
                    set_d   = i_miss_set;
                    way_d   = i_miss_way;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_mem_req_valid = !i_halt_all;
                if (!i_halt_all && i_mem_req_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                o_mem_data_ready = !i_halt_all;
                if (!i_halt_all && i_mem_data_valid) begin
                    for (int k = 0; k < 3; k++) begin
                        if (beat_q[1:0] == 2'(k)) begin
                            pack_d[k*WORD_WIDTH +: WORD_WIDTH] = i_mem_data;
                        end
                    end
                    // Fourth beat of a row: emit the write from a separate
                    // register so the next beat can land in pack without a stall.
                    if (beat_q[1:0] == 2'd3) begin
                        w_valid_d = 1'b1;
                        w_data_d  = {i_mem_data, pack_q};
                        w_off_d   = beat_q[B_OFFSET_BITS_WIDTH-1:2];
                    end
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!i_halt_all) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!i_halt_all) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_mem_req_addr        = {tag_q, set_q};
    assign o_w_set_bits          = set_q;
    assign o_w_way_index         = way_q;
    assign o_w_block_offset_bits = w_off_q;
    assign o_w_data              = w_data_q;
    assign o_w_valid             = w_valid_q;
    assign o_stop_write_clk      = ~w_valid_q;
    assign o_fill_done           = (state_q == DONE);
    assign o_fill_tag            = tag_q;
    assign o_fill_set            = set_q;
    assign o_fill_way            = way_q;

endmodule

// File: tb/tb_line_refill_engine.sv
// ---------------------------------------------------------------------------
// tb_line_refill_engine
//
// Directed bench for line_refill_engine. Inputs are driven and outputs are
// sampled on the falling clock edge; expected write words, offsets and
// strobe timing come from the beats the bench itself chose to present.
// ---------------------------------------------------------------------------
module tb_line_refill_engine;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_halt_all;
    logic        i_miss_valid;
    logic [7:0]  i_miss_tag;
    logic [3:0]  i_miss_set;
    logic [1:0]  i_miss_way;
    logic        o_miss_ready;
    logic        o_mem_req_valid;
    logic [11:0] o_mem_req_addr;
    logic        i_mem_req_ready;
    logic [19:0] i_mem_data;
    logic        i_mem_data_valid;
    logic        o_mem_data_ready;
    logic [3:0]  o_w_set_bits;
    logic [1:0]  o_w_way_index;
    logic [1:0]  o_w_block_offset_bits;
    logic [79:0] o_w_data;
    logic        o_w_valid;
    logic        o_stop_write_clk;
    logic        o_fill_done;
    logic [7:0]  o_fill_tag;
    logic [3:0]  o_fill_set;
    logic [1:0]  o_fill_way;

    int checks = 0;
    int errors = 0;

    logic [7:0]  nextTag;
    logic [3:0]  nextSet;
    logic [1:0]  nextWay;

    always #5 clk = ~clk;

    line_refill_engine #(
        .SET_BITS_WIDTH(4), .TAG_BITS_WIDTH(8), .NUM_WAYS(4),
        .B_OFFSET_BITS_WIDTH(4), .WORD_WIDTH(20)
    ) dut (
        .clk(clk), .arst_n(arst_n), .i_halt_all(i_halt_all),
        .i_miss_valid(i_miss_valid), .i_miss_tag(i_miss_tag),
        .i_miss_set(i_miss_set), .i_miss_way(i_miss_way),
        .o_miss_ready(o_miss_ready), .o_mem_req_valid(o_mem_req_valid),
        .o_mem_req_addr(o_mem_req_addr), .i_mem_req_ready(i_mem_req_ready),
        .i_mem_data(i_mem_data), .i_mem_data_valid(i_mem_data_valid),
        .o_mem_data_ready(o_mem_data_ready), .o_w_set_bits(o_w_set_bits),
        .o_w_way_index(o_w_way_index),
        .o_w_block_offset_bits(o_w_block_offset_bits),
        .o_w_data(o_w_data), .o_w_valid(o_w_valid),
        .o_stop_write_clk(o_stop_write_clk), .o_fill_done(o_fill_done),
        .o_fill_tag(o_fill_tag), .o_fill_set(o_fill_set), .o_fill_way(o_fill_way)
    );

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".missReady"}, o_miss_ready, 1);
        checkOutput({tag, ".stopWriteClk"}, o_stop_write_clk, 1);
        checkOutput({tag, ".wValid"}, o_w_valid, 0);
        checkOutput({tag, ".wData"}, o_w_data, 0);
        checkOutput({tag, ".wOffset"}, o_w_block_offset_bits, 0);
        checkOutput({tag, ".memReqValid"}, o_mem_req_valid, 0);
        checkOutput({tag, ".memReqAddr"}, o_mem_req_addr, 0);
        checkOutput({tag, ".memDataReady"}, o_mem_data_ready, 0);
        checkOutput({tag, ".fillDone"}, o_fill_done, 0);
        checkOutput({tag, ".fillTag"}, o_fill_tag, 0);
    endtask

    // Runs one refill starting at a falling edge with the engine in IDLE and
    // ends at a falling edge back in IDLE (or right after an aborting reset).
    task automatic applyStimulus(input logic [7:0] tg, input logic [3:0] st, input logic [1:0] wy,
                                 input int toggleMode, input int haltMode, input int holdMiss,
                                 input int abortAfter, input int reqStall);
        int          beat;
        int          cyc;
        logic        expW;
        logic [1:0]  expOff;
        logic [79:0] expData;
        logic [19:0] lanes [4];
        logic        valid;

        i_miss_valid = 1'b1;
        i_miss_tag   = tg;
        i_miss_set   = st;
        i_miss_way   = wy;
        #1;
        checkOutput("idle.missReady", o_miss_ready, 1);

        @(negedge clk);
        if (holdMiss != 0) begin
            i_miss_tag = nextTag;
            i_miss_set = nextSet;
            i_miss_way = nextWay;
        end else begin
            i_miss_valid = 1'b0;
        end
        i_mem_req_ready  = 1'b0;
        i_mem_data_valid = 1'b1;
        i_mem_data       = 20'hABCDE;
        for (int i = 0; i < reqStall; i++) begin
            #1;
            checkOutput("reqStall.memReqValid", o_mem_req_valid, 1);
            checkOutput("reqStall.memDataReady", o_mem_data_ready, 0);
            @(negedge clk);
        end
        i_mem_data_valid = 1'b0;
        i_mem_req_ready  = 1'b1;
        #1;
        checkOutput("req.memReqValid", o_mem_req_valid, 1);
        checkOutput("req.memReqAddr", o_mem_req_addr, {68'd0, tg, st});
        checkOutput("req.missReady", o_miss_ready, 0);

        beat    = 0;
        cyc     = 0;
        expW    = 1'b0;
        expOff  = 2'd0;
        expData = '0;
        while (beat < 16) begin
            @(negedge clk);
            i_mem_req_ready = 1'b0;
            checkOutput("fill.wValid", o_w_valid, expW);
            checkOutput("fill.stopWriteClk", o_stop_write_clk, !expW);
            checkOutput("fill.memReqValid", o_mem_req_valid, 0);
            if (expW) begin
                checkOutput("fill.wData", o_w_data, expData);
                checkOutput("fill.wOffset", o_w_block_offset_bits, expOff);
                checkOutput("fill.wSet", o_w_set_bits, st);
                checkOutput("fill.wWay", o_w_way_index, wy);
            end
            if (holdMiss != 0) checkOutput("fill.missReadyBusy", o_miss_ready, 0);
            cyc++;
            if (cyc > 200) begin
                checkOutput("fill.timeoutBeats", beat, 16);
                break;
            end
            if (abortAfter >= 0 && beat == abortAfter + 1) begin
                i_mem_data_valid = 1'b0;
                arst_n = 1'b0;
                #1;
                checkResetValues("abort");
                #1;
                arst_n = 1'b1;
                i_miss_valid = 1'b0;
                return;
            end
            if (haltMode != 0 && expW && expOff == 2'd1) begin
                for (int h = 0; h < 3; h++) begin
                    i_halt_all       = 1'b1;
                    i_mem_data_valid = 1'b1;
                    i_mem_data       = 20'hFFFFF;
                    #1;
                    checkOutput("halt.memDataReady", o_mem_data_ready, 0);
                    @(negedge clk);
                    checkOutput("halt.wValidHeld", o_w_valid, 1);
                    checkOutput("halt.wDataHeld", o_w_data, expData);
                end
                i_halt_all       = 1'b0;
                i_mem_data_valid = 1'b0;
                expW             = 1'b0;
                continue;
            end
            valid            = (toggleMode != 0) ? (cyc % 2 == 1) : 1'b1;
            i_mem_data_valid = valid;
            i_mem_data       = 20'(beat);
            #1;
            checkOutput("fill.memDataReady", o_mem_data_ready, 1);
            expW = valid && (beat % 4 == 3);
            if (valid) begin
                lanes[beat % 4] = 20'(beat);
                if (expW) begin
                    expData = {lanes[3], lanes[2], lanes[1], lanes[0]};
                    expOff  = 2'(beat / 4);
                end
                beat++;
            end
        end

        // FLUSH: final write visible, beats no longer accepted
        @(negedge clk);
        i_mem_data_valid = 1'b1;
        i_mem_data       = 20'h12345;
        #1;
        checkOutput("flush.wValid", o_w_valid, 1);
        checkOutput("flush.wOffset", o_w_block_offset_bits, 3);
        checkOutput("flush.wData", o_w_data, expData);
        checkOutput("flush.fillDone", o_fill_done, 0);
        checkOutput("flush.memDataReady", o_mem_data_ready, 0);

        // DONE: one-cycle completion pulse after the last write
        @(negedge clk);
        i_mem_data_valid = 1'b0;
        checkOutput("done.fillDone", o_fill_done, 1);
        checkOutput("done.wValid", o_w_valid, 0);
        checkOutput("done.stopWriteClk", o_stop_write_clk, 1);
        checkOutput("done.fillTag", o_fill_tag, tg);
        checkOutput("done.fillSet", o_fill_set, st);
        checkOutput("done.fillWay", o_fill_way, wy);
        checkOutput("done.missReady", o_miss_ready, 0);

        @(negedge clk);
        checkOutput("idle.fillDoneCleared", o_fill_done, 0);
        checkOutput("idle.missReadyBack", o_miss_ready, 1);
    endtask

    initial begin
        arst_n           = 1'b0;
        i_halt_all       = 1'b0;
        i_miss_valid     = 1'b0;
        i_miss_tag       = '0;
        i_miss_set       = '0;
        i_miss_way       = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_data       = '0;
        i_mem_data_valid = 1'b0;
        nextTag          = 8'h3C;
        nextSet          = 4'h9;
        nextWay          = 2'd1;
        #2;
        checkResetValues("reset");
        #10;
        arst_n = 1'b1;
        @(negedge clk);

        $display("[TB] back-to-back fill");
        applyStimulus(8'hA5, 4'd3, 2'd2, 0, 0, 0, -1, 0);

        $display("[TB] fill with toggling beat valid");
        applyStimulus(8'hA5, 4'd3, 2'd2, 1, 0, 0, -1, 0);

        $display("[TB] halt while write pending");
        applyStimulus(8'h5C, 4'd7, 2'd1, 0, 1, 0, -1, 0);

        $display("[TB] second miss during fill");
        applyStimulus(8'h11, 4'd1, 2'd0, 0, 0, 1, -1, 0);
        applyStimulus(nextTag, nextSet, nextWay, 0, 0, 0, -1, 0);

        $display("[TB] reset mid-fill");
        applyStimulus(8'h22, 4'd2, 2'd3, 0, 0, 0, 9, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("postAbort.fillDone", o_fill_done, 0);
            checkOutput("postAbort.wValid", o_w_valid, 0);
            checkOutput("postAbort.missReady", o_miss_ready, 1);
        end
        applyStimulus(8'h33, 4'd4, 2'd1, 0, 0, 0, -1, 0);

        $display("[TB] memory request stall");
        applyStimulus(8'h44, 4'd5, 2'd0, 0, 0, 0, -1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
